// File: rtl/ss_crosb_pkg.sv
// Shared types and helpers for the crossbar arbitration slice.
// Provides the arbiter state enum, the ceiling-log2 helper and the input-count limit.
package ss_crosb_pkg;

  localparam int CROSB_MAX_INPUTS = 10;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Ceiling log2, never below 1 so a select port always has at least one bit.
  function automatic int log2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ss_1h_to_b.sv
// Crossbar one-hot to binary encoder; an all-zero input decodes to index 0.
// Works by OR-ing the indices of set bits, so it is one gate level deep per output bit.
module ss_1h_to_b
  import ss_crosb_pkg::*;
#(
  parameter int input_width  = 4,
  parameter int output_width = log2(input_width)
) (
  input  logic [input_width-1:0]  i_onehot,
  output logic [output_width-1:0] o_bin
);

  always_comb begin
    o_bin = '0;
    for (int k = 0; k < input_width; k++) begin
      if (i_onehot[k]) o_bin = o_bin | output_width'(k);
    end
  end

endmodule

// File: rtl/ss_crosb_rr_arb.sv
// Per-output-port packet-locked round-robin arbiter: one-hot grant held from
// head arbitration until the tail flit transfers, plus its binary mux select.
module ss_crosb_rr_arb
  import ss_crosb_pkg::*;
#(
  parameter int N_INPUTS = 4,
  parameter int SEL_W    = log2(N_INPUTS)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [N_INPUTS-1:0] i_req,
  input  logic                i_xfer,
  input  logic                i_tail,
  output logic [N_INPUTS-1:0] o_gnt,
  output logic                o_gnt_valid,
  output logic [SEL_W-1:0]    o_sel,
  output logic                o_err
);

  if (N_INPUTS < 2 || N_INPUTS > CROSB_MAX_INPUTS) begin : g_bad_inputs
    $error("ss_crosb_rr_arb: N_INPUTS=%0d outside 2..%0d", N_INPUTS, CROSB_MAX_INPUTS);
  end
  if (SEL_W < log2(N_INPUTS)) begin : g_bad_sel_w
    $error("ss_crosb_rr_arb: SEL_W=%0d too narrow for N_INPUTS=%0d", SEL_W, N_INPUTS);
  end

  arb_state_t            state_p0, state_p1;
  logic [N_INPUTS-1:0]   gnt_p0, gnt_p1;
  logic [SEL_W-1:0]      ptr_p0, ptr_p1;
  logic                  err_p0, err_p1;

  logic [N_INPUTS-1:0]   above_ptr;
  logic [2*N_INPUTS-1:0] dbl_req;
  logic [SEL_W-1:0]      pick_idx;

  // Rotating priority: the lower half holds requests strictly above ptr, the
  // upper half all requests, so the lowest set bit is the first one after ptr.
  always_comb begin
    above_ptr = '0;
    for (int k = 0; k < N_INPUTS; k++) begin
      above_ptr[k] = (k > int'(ptr_p1));
    end
    dbl_req  = {i_req, i_req & above_ptr};
    pick_idx = '0;
    for (int k = 2*N_INPUTS-1; k >= 0; k--) begin
      if (dbl_req[k]) pick_idx = (k >= N_INPUTS) ? SEL_W'(k - N_INPUTS) : SEL_W'(k);
    end
  end

  always_comb begin
    state_p0 = state_p1;
    gnt_p0   = gnt_p1;
    ptr_p0   = ptr_p1;
    err_p0   = err_p1;
    case (state_p1)
      ARB_IDLE: begin
        if (i_xfer) err_p0 = 1'b1;
        if (|i_req) begin
          gnt_p0   = N_INPUTS'(1) << pick_idx;
          ptr_p0   = pick_idx;
          state_p0 = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        // Only a transferred tail ends the packet; request drops are ignored.
        if (i_xfer && i_tail) begin
          gnt_p0   = '0;
          state_p0 = ARB_IDLE;
        end
      end
      default: begin
        gnt_p0   = '0;
        state_p0 = ARB_IDLE;
      end
    endcase
  end

  // Stage p0 -> p1: registered arbitration state and grant.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_p1 <= ARB_IDLE;
      gnt_p1   <= '0;
      ptr_p1   <= SEL_W'(N_INPUTS - 1);
      err_p1   <= 1'b0;
    end else begin
      state_p1 <= state_p0;
      gnt_p1   <= gnt_p0;
      ptr_p1   <= ptr_p0;
      err_p1   <= err_p0;
    end
  end

  assign o_gnt       = gnt_p1;
  assign o_gnt_valid = |gnt_p1;
  assign o_err       = err_p1;

  ss_1h_to_b #(
    .input_width  (N_INPUTS),
    .output_width (SEL_W)
  ) u_sel_enc (
    .i_onehot (gnt_p1),
    .o_bin    (o_sel)
  );

endmodule

// File: tb/tb_ss_crosb_rr_arb.sv
// Self-checking bench for ss_crosb_rr_arb: directed scenarios plus randomized
// traffic compared every cycle against a packet-level round-robin model.
module tb_ss_crosb_rr_arb;

  localparam int N  = 4;
  localparam int SW = 2;

  logic          i_clk;
  logic          i_rst;
  logic [N-1:0]  i_req;
  logic          i_xfer;
  logic          i_tail;
  logic [N-1:0]  o_gnt;
  logic          o_gnt_valid;
  logic [SW-1:0] o_sel;
  logic          o_err;

  int n_chk;
  int n_err;

  // Reference model: who owns the output, last winner, sticky error.
  int m_ptr;
  bit m_lock;
  int m_idx;
  bit m_err;

  ss_crosb_rr_arb #(.N_INPUTS(N), .SEL_W(SW)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req       (i_req),
    .i_xfer      (i_xfer),
    .i_tail      (i_tail),
    .o_gnt       (o_gnt),
    .o_gnt_valid (o_gnt_valid),
    .o_sel       (o_sel),
    .o_err       (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_ptr  = N - 1;
    m_lock = 1'b0;
    m_idx  = 0;
    m_err  = 1'b0;
  endfunction

  function automatic void model_step(input logic [N-1:0] req, input logic xfer, input logic tail);
    if (!m_lock) begin
      if (xfer) m_err = 1'b1;
      for (int d = 1; d <= N; d++) begin
        int k;
        k = (m_ptr + d) % N;
        if (req[k]) begin
          m_idx  = k;
          m_ptr  = k;
          m_lock = 1'b1;
          break;
        end
      end
    end else if (xfer && tail) begin
      m_lock = 1'b0;
    end
  endfunction

  task automatic check_all(input string tag);
    logic [N-1:0] exp_gnt;
    exp_gnt = m_lock ? (N'(1) << m_idx) : '0;
    chk({tag, "_gnt"},   32'(o_gnt),       32'(exp_gnt));
    chk({tag, "_valid"}, 32'(o_gnt_valid), 32'(m_lock));
    chk({tag, "_sel"},   32'(o_sel),       m_lock ? 32'(m_idx) : 32'd0);
    chk({tag, "_err"},   32'(o_err),       32'(m_err));
  endtask

  task automatic cycle(input logic [N-1:0] req, input logic xfer, input logic tail);
    i_req  = req;
    i_xfer = xfer;
    i_tail = tail;
    @(posedge i_clk);
    model_step(req, xfer, tail);
    #1;
    check_all("cyc");
  endtask

  task automatic do_reset();
    i_rst  = 1'b1;
    i_req  = '0;
    i_xfer = 1'b0;
    i_tail = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    model_reset();
    #1;
    check_all("rst");
  endtask

  // Reset asserted between edges must drop the grant without waiting for a clock.
  task automatic async_reset();
    #2;
    i_rst = 1'b1;
    #1;
    chk("arst_gnt",   32'(o_gnt),       32'd0);
    chk("arst_valid", 32'(o_gnt_valid), 32'd0);
    model_reset();
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_err  = 0;
    i_rst  = 1'b1;
    i_req  = '0;
    i_xfer = 1'b0;
    i_tail = 1'b0;
    model_reset();

    // Reset then single request
    do_reset();
    cycle(4'b0100, 1'b0, 1'b0);
    chk("single_gnt",   32'(o_gnt),       32'b0100);
    chk("single_sel",   32'(o_sel),       32'd2);
    chk("single_valid", 32'(o_gnt_valid), 32'd1);
    cycle(4'b0100, 1'b1, 1'b1);

    // Fairness with 2-flit packets
    do_reset();
    for (int p = 0; p < 5; p++) begin
      cycle(4'b1111, 1'b0, 1'b0);
      chk("fair_order", 32'(o_sel), 32'(p % N));
      cycle(4'b1111, 1'b1, 1'b0);
      cycle(4'b1111, 1'b1, 1'b1);
      chk("fair_bubble", 32'(o_gnt_valid), 32'd0);
    end

    // Lock hold while the requester changes, then the new requester wins
    do_reset();
    cycle(4'b0010, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(4'b1000, 1'b1, 1'b0);
      chk("lock_xfer_gnt", 32'(o_gnt), 32'b0010);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1000, 1'b0, (i == 1));
      chk("lock_stall_gnt", 32'(o_gnt), 32'b0010);
    end
    chk("lock_tail_noerr", 32'(o_err), 32'd0);
    cycle(4'b1000, 1'b1, 1'b1);
    cycle(4'b1000, 1'b0, 1'b0);
    chk("lock_next_sel", 32'(o_sel), 32'd3);

    // Pointer wrap from last winner 3
    cycle(4'b1001, 1'b1, 1'b1);
    cycle(4'b1001, 1'b0, 1'b0);
    chk("wrap_first", 32'(o_sel), 32'd0);
    cycle(4'b1001, 1'b1, 1'b1);
    cycle(4'b1001, 1'b0, 1'b0);
    chk("wrap_second", 32'(o_sel), 32'd3);
    cycle(4'b0000, 1'b1, 1'b1);

    // Sticky error from a transfer while idle
    cycle(4'b0000, 1'b1, 1'b0);
    chk("err_set", 32'(o_err), 32'd1);
    for (int i = 0; i < 3; i++) cycle(4'b0001, (i == 1), (i == 1));
    chk("err_hold", 32'(o_err), 32'd1);
    do_reset();
    chk("err_clear", 32'(o_err), 32'd0);

    // Asynchronous reset in the middle of a packet
    cycle(4'b0100, 1'b0, 1'b0);
    cycle(4'b0100, 1'b1, 1'b0);
    async_reset();
    cycle(4'b1110, 1'b0, 1'b0);
    chk("arst_winner", 32'(o_sel), 32'd1);
    cycle(4'b0000, 1'b1, 1'b1);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] req;
      logic         xfer;
      logic         tail;
      req  = N'($urandom_range(0, 15));
      tail = ($urandom_range(0, 2) == 0);
      if (m_lock) xfer = ($urandom_range(0, 3) != 0);
      else        xfer = ($urandom_range(0, 99) == 0);
      cycle(req, xfer, tail);
      if ($urandom_range(0, 299) == 0) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
